// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the mc_core_hs multi-cycle MIPS core.
//   - opcode / funct encodings of the supported subset
//   - control FSM state enum
//   - fault codes reported on the core's fault output
//   - 3-bit ALU control encodings and the ALU evaluation helpers
package mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [1:0] FLT_NONE     = 2'd0;
    localparam logic [1:0] FLT_ILLEGAL  = 2'd1;
    localparam logic [1:0] FLT_MISALIGN = 2'd2;
    localparam logic [1:0] FLT_TIMEOUT  = 2'd3;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXEC,
        S_ALUWB,
        S_BRANCH,
        S_ADDIEX,
        S_ADDIWB,
        S_JUMP,
        S_HALT
    } state_t;

    function automatic logic funct_ok(input logic [5:0] f);
        return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) ||
               (f == FN_OR)  || (f == FN_SLT);
    endfunction

    function automatic logic [2:0] alu_ctl_of(input logic [5:0] f);
        logic [2:0] c;
        case (f)
            FN_SUB:  c = ALU_SUB;
            FN_AND:  c = ALU_AND;
            FN_OR:   c = ALU_OR;
            FN_SLT:  c = ALU_SLT;
            default: c = ALU_ADD;
        endcase
        return c;
    endfunction

    // 32-bit wrap-around arithmetic; slt compares as signed.
    function automatic logic [31:0] alu_op(input logic [2:0]  ctl,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        logic [31:0] y;
        case (ctl)
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_SUB: y = a - b;
            ALU_SLT: y = {31'd0, ($signed(a) < $signed(b))};
            default: y = a + b;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: control FSM of mc_core_hs.
//   Holds the state register, next-state logic, fault/halt registers and the
//   per-transfer memory wait counter.
// Ports:
//   clk, reset        clock / synchronous active-low reset
//   i_opcode, i_funct fields of the current instruction register
//   i_misalign        effective address computed in MEMADR is not word aligned
//   i_mem_ready       memory handshake completion
//   o_state           current state (datapath strobes decode from it)
//   o_fault, o_halted registered fault code / halted flag
//   o_mem_req, o_mem_we memory request controls
//   o_alu_ctl         3-bit ALU control for EXEC
module mc_ctrl_fsm
    import mc_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    input  logic       i_misalign,
    input  logic       i_mem_ready,
    output state_t     o_state,
    output logic [1:0] o_fault,
    output logic       o_halted,
    output logic       o_mem_req,
    output logic       o_mem_we,
    output logic [2:0] o_alu_ctl
);

    localparam logic [31:0] TMO_LAST = 32'(MEM_TIMEOUT) - 32'd1;

    state_t      r_state;
    logic [1:0]  r_fault;
    logic        r_halted;
    logic [31:0] r_wait;
    logic        w_mem_state;
    logic        w_tmo;

    assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMRD) ||
                         (r_state == S_MEMWR);
    // The wait counter only advances while a request is unanswered, so the
    // last permitted wait cycle is MEM_TIMEOUT-1.
    assign w_tmo = (MEM_TIMEOUT != 0) && (r_wait == TMO_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= S_FETCH;
            r_fault  <= FLT_NONE;
            r_halted <= 1'b0;
            r_wait   <= '0;
        end else begin
            case (r_state)
                S_FETCH, S_MEMRD, S_MEMWR: begin
                    if (i_mem_ready) begin
                        r_wait <= '0;
                        if (r_state == S_FETCH)
                            r_state <= S_DECODE;
                        else if (r_state == S_MEMRD)
                            r_state <= S_MEMWB;
                        else
                            r_state <= S_FETCH;
                    end else if (w_tmo) begin
                        r_wait   <= '0;
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
                        r_fault  <= FLT_TIMEOUT;
                    end else begin
                        r_wait <= r_wait + 32'd1;
                    end
                end
                S_DECODE: begin
                    case (i_opcode)
                        OP_LW, OP_SW: r_state <= S_MEMADR;
                        OP_RTYPE:     r_state <= S_EXEC;
                        OP_BEQ:       r_state <= S_BRANCH;
                        OP_ADDI:      r_state <= S_ADDIEX;
                        OP_J:         r_state <= S_JUMP;
                        default: begin
                            r_state  <= S_HALT;
                            r_halted <= 1'b1;
                            r_fault  <= FLT_ILLEGAL;
                        end
                    endcase
                end
                S_MEMADR: begin
                    if (i_misalign) begin
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
                        r_fault  <= FLT_MISALIGN;
                    end else if (i_opcode == OP_LW) begin
                        r_state <= S_MEMRD;
                    end else begin
                        r_state <= S_MEMWR;
                    end
                end
                S_EXEC: begin
                    if (funct_ok(i_funct)) begin
                        r_state <= S_ALUWB;
                    end else begin
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
                        r_fault  <= FLT_ILLEGAL;
                    end
                end
                S_ADDIEX: r_state <= S_ADDIWB;
                S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: r_state <= S_FETCH;
                S_HALT:   r_state <= S_HALT;
                default: begin
                    r_state  <= S_HALT;
                    r_halted <= 1'b1;
                end
            endcase
        end
    end

    assign o_state   = r_state;
    assign o_fault   = r_fault;
    assign o_halted  = r_halted;
    // Gated by reset so no request is visible while the core is held.
    assign o_mem_req = reset && w_mem_state;
    assign o_mem_we  = (r_state == S_MEMWR);
    assign o_alu_ctl = (r_state == S_EXEC) ? alu_ctl_of(i_funct) : ALU_ADD;

endmodule

// File: rtl/mc_core_hs.sv
// mc_core_hs: multi-cycle MIPS core (lw, sw, add, sub, and, or, slt, beq,
// addi, j) with a req/ready unified memory port and fault detection.
// Optional feature macro: MC_INSTRET_CNT_EN adds the 32-bit instret output.
// Ports:
//   clk, reset      clock / synchronous active-low reset
//   mem_req/we/addr/wdata, mem_rdata, mem_ready   memory handshake
//   halted, fault   core stopped / fault code (see mc_pkg FLT_*)
//   pc_o            architectural PC
//   instret         retired instruction count (MC_INSTRET_CNT_EN only)
//   dbg_raddr/rdata combinational register-file debug read
module mc_core_hs
    import mc_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          NUM_REGS    = 32,
    parameter int unsigned MEM_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        halted,
    output logic [1:0]  fault,
    output logic [31:0] pc_o,
`ifdef MC_INSTRET_CNT_EN
    output logic [31:0] instret,
`endif
    input  logic [4:0]  dbg_raddr,
    output logic [31:0] dbg_rdata
);

    localparam int RW = $clog2(NUM_REGS);

    logic [31:0] r_pc, r_ir, r_data, r_a, r_b, r_aluout;
    logic [31:0] r_rf [NUM_REGS];

    state_t      w_state;
    logic [2:0]  w_alu_ctl;
    logic [31:0] w_simm, w_addr_calc, w_alu;
    logic [4:0]  w_rs5, w_rt5, w_rd5;
    logic [RW-1:0] w_rs, w_rt, w_rd, w_dbg;
    logic [31:0] w_rs_val, w_rt_val;
    logic        w_misalign;
    logic        w_rf_we;
    logic [RW-1:0] w_rf_wa;
    logic [31:0] w_rf_wd;

    assign w_simm      = {{16{r_ir[15]}}, r_ir[15:0]};
    assign w_rs5       = r_ir[25:21];
    assign w_rt5       = r_ir[20:16];
    assign w_rd5       = r_ir[15:11];
    assign w_rs        = w_rs5[RW-1:0];
    assign w_rt        = w_rt5[RW-1:0];
    assign w_rd        = w_rd5[RW-1:0];
    assign w_dbg       = dbg_raddr[RW-1:0];
    assign w_addr_calc = r_a + w_simm;
    assign w_misalign  = |w_addr_calc[1:0];
    assign w_alu       = alu_op(w_alu_ctl, r_a, r_b);

    // Register 0 is hard-wired to zero on every read port.
    assign w_rs_val  = (w_rs  == '0) ? 32'd0 : r_rf[w_rs];
    assign w_rt_val  = (w_rt  == '0) ? 32'd0 : r_rf[w_rt];
    assign dbg_rdata = (w_dbg == '0) ? 32'd0 : r_rf[w_dbg];

    mc_ctrl_fsm #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_fsm (
        .clk         (clk),
        .reset       (reset),
        .i_opcode    (r_ir[31:26]),
        .i_funct     (r_ir[5:0]),
        .i_misalign  (w_misalign),
        .i_mem_ready (mem_ready),
        .o_state     (w_state),
        .o_fault     (fault),
        .o_halted    (halted),
        .o_mem_req   (mem_req),
        .o_mem_we    (mem_we),
        .o_alu_ctl   (w_alu_ctl)
    );

    // Data transfers use ALUOut; everything else (fetch) uses the PC.
    // All sources are registers that only move on handshake, so the
    // address and write data stay stable across wait cycles.
    assign mem_addr  = ((w_state == S_MEMRD) || (w_state == S_MEMWR)) ?
                       {r_aluout[31:2], 2'b00} : {r_pc[31:2], 2'b00};
    assign mem_wdata = r_b;
    assign pc_o      = r_pc;

    always_comb begin
        w_rf_we = 1'b0;
        w_rf_wa = w_rt;
        w_rf_wd = r_aluout;
        case (w_state)
            S_MEMWB: begin
                w_rf_we = 1'b1;
                w_rf_wd = r_data;
            end
            S_ALUWB: begin
                w_rf_we = 1'b1;
                w_rf_wa = w_rd;
            end
            S_ADDIWB: w_rf_we = 1'b1;
            default: ;
        endcase
    end

    // Register file is deliberately not reset.
    always_ff @(posedge clk) begin
        if (reset && w_rf_we && (w_rf_wa != '0))
            r_rf[w_rf_wa] <= w_rf_wd;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pc     <= RESET_PC;
            r_ir     <= '0;
            r_data   <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_aluout <= '0;
        end else begin
            case (w_state)
                S_FETCH: begin
                    if (mem_ready) begin
                        r_ir <= mem_rdata;
                        r_pc <= r_pc + 32'd4;
                    end
                end
                S_DECODE: begin
                    r_a      <= w_rs_val;
                    r_b      <= w_rt_val;
                    // Branch target precomputed; PC already points past beq.
                    r_aluout <= r_pc + {w_simm[29:0], 2'b00};
                end
                S_MEMADR, S_ADDIEX: r_aluout <= w_addr_calc;
                S_MEMRD:  if (mem_ready) r_data <= mem_rdata;
                S_EXEC:   r_aluout <= w_alu;
                S_BRANCH: if (r_a == r_b) r_pc <= r_aluout;
                S_JUMP:   r_pc <= {r_pc[31:28], r_ir[25:0], 2'b00};
                default: ;
            endcase
        end
    end

`ifdef MC_INSTRET_CNT_EN
    logic [31:0] r_instret;
    logic        w_retire;

    // Counted on the transition back into FETCH after a completed instruction.
    assign w_retire = (w_state == S_MEMWB) || (w_state == S_ALUWB) ||
                      (w_state == S_ADDIWB) || (w_state == S_BRANCH) ||
                      (w_state == S_JUMP) || ((w_state == S_MEMWR) && mem_ready);

    always_ff @(posedge clk) begin
        if (!reset)
            r_instret <= '0;
        else if (w_retire)
            r_instret <= r_instret + 32'd1;
    end

    assign instret = r_instret;
`endif

endmodule
